// File: rtl/fifo_pkg.sv
// fifo_pkg: pointer-width derivation and Gray/binary conversion shared by both FIFO clock domains.
// Functions work on a fixed 32-bit container; callers zero-extend and truncate to their pointer width.
package fifo_pkg;

  localparam int MAX_PTR_WIDTH = 32;

  typedef logic [MAX_PTR_WIDTH-1:0] ptr_word_t;

  // A FIFO with 2**addr_width entries needs one extra pointer bit to tell full from empty.
  function automatic int ptr_width(input int addr_width);
    return addr_width + 1;
  endfunction

  function automatic ptr_word_t bin2gray(input ptr_word_t bin);
    return bin ^ (bin >> 1);
  endfunction

  // Zero-extended upper bits decode to zero, so the full-width prefix XOR is exact for any width.
  function automatic ptr_word_t gray2bin(input ptr_word_t gray);
    ptr_word_t bin;
    bin[MAX_PTR_WIDTH-1] = gray[MAX_PTR_WIDTH-1];
    for (int i = MAX_PTR_WIDTH - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/fifo_rd_ctrl_if.sv
// fifo_rd_ctrl_if: ready/valid output stream from the FIFO read controller to its consumer.
// The controller takes the master modport, the consumer the slave modport.
interface fifo_rd_ctrl_if #(
  parameter int DATA_WIDTH = 8
);

  logic [DATA_WIDTH-1:0] dout;
  logic                  dout_valid;
  logic                  dout_ready;

  modport master (
    output dout,
    output dout_valid,
    input  dout_ready
  );

  modport slave (
    input  dout,
    input  dout_valid,
    output dout_ready
  );

endinterface

// File: rtl/cdc_sync_2ff.sv
// cdc_sync_2ff: two-flop synchroniser for a Gray-coded bus crossing into the local clock domain.
// Only one bit of the input may change per source update; both stages clear on rst_n.
module cdc_sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // NOTE: non-blocking assignments make both stages sample their pre-edge inputs; blocking
  // assignments here would collapse the chain into a single flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: read-domain controller of an async FIFO with a 2-entry output skid buffer.
// Optional registered fill level (rd_level) is built only when FIFO_RD_LEVEL_EN is defined.
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst_n,
  input  logic [ADDR_WIDTH:0]   wr_ptr_gray,
  output logic [ADDR_WIDTH:0]   rd_ptr_gray,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  fifo_rd_ctrl_if.master        rd_if,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   rd_level
);

  localparam int PTR_WIDTH = ptr_width(ADDR_WIDTH);

  logic [PTR_WIDTH-1:0]  wr_sync_gray;
  logic [PTR_WIDTH-1:0]  rd_bin_q,  rd_bin_d;
  logic [PTR_WIDTH-1:0]  rd_gray_q, rd_gray_d;
  logic                  in_flight_q;
  logic [1:0]            occ_q, occ_d;
  logic [DATA_WIDTH-1:0] buf0_q, buf0_d;
  logic [DATA_WIDTH-1:0] buf1_q, buf1_d;
  logic                  mem_empty;
  logic                  xfer;
  logic                  issue;
  logic                  dout_valid;

  cdc_sync_2ff #(
    .WIDTH (PTR_WIDTH)
  ) u_wr_ptr_sync (
    .clk   (rd_clk),
    .rst_n (rd_rst_n),
    .d_i   (wr_ptr_gray),
    .q_o   (wr_sync_gray)
  );

  assign mem_empty  = (rd_gray_q == wr_sync_gray);
  assign dout_valid = (occ_q != 2'd0);
  assign xfer       = dout_valid && rd_if.dout_ready;

  // Occupancy after this edge, counting the word landing from memory and the one leaving.
  // Issuing against this net figure keeps one word per cycle flowing with ready held high.
  assign occ_d = occ_q + 2'(in_flight_q) - 2'(xfer);
  assign issue = !mem_empty && (occ_d < 2'd2);

  always_comb begin
    rd_bin_d  = rd_bin_q + PTR_WIDTH'(issue);
    rd_gray_d = PTR_WIDTH'(bin2gray(ptr_word_t'(rd_bin_d)));
  end

  // NOTE: every variable written here gets a default first, so no path can leave one
  // unassigned and infer a latch.
  always_comb begin
    buf0_d = buf0_q;
    buf1_d = buf1_q;
    if (xfer) begin
      buf0_d = buf1_q;
    end
    if (in_flight_q) begin
      if (occ_q == 2'(xfer)) begin
        buf0_d = mem_rd_data;
      end else begin
        buf1_d = mem_rd_data;
      end
    end
  end

  // NOTE: the buffer words are reset because buf0 drives dout, which must read 0 out of reset;
  // bulk storage without that need would normally be left unreset.
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      rd_bin_q    <= '0;
      rd_gray_q   <= '0;
      in_flight_q <= 1'b0;
      occ_q       <= 2'd0;
      buf0_q      <= '0;
      buf1_q      <= '0;
    end else begin
      rd_bin_q    <= rd_bin_d;
      rd_gray_q   <= rd_gray_d;
      in_flight_q <= issue;
      occ_q       <= occ_d;
      buf0_q      <= buf0_d;
      buf1_q      <= buf1_d;
    end
  end

  assign rd_ptr_gray      = rd_gray_q;
  assign rd_addr          = rd_bin_q[ADDR_WIDTH-1:0];
  assign rd_if.dout       = buf0_q;
  assign rd_if.dout_valid = dout_valid;
  assign empty            = mem_empty && !in_flight_q && (occ_q == 2'd0);

`ifdef FIFO_RD_LEVEL_EN
  logic [PTR_WIDTH-1:0] wr_sync_bin;
  logic [PTR_WIDTH-1:0] rd_level_q;

  assign wr_sync_bin = PTR_WIDTH'(gray2bin(ptr_word_t'(wr_sync_gray)));

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      rd_level_q <= '0;
    end else begin
      rd_level_q <= wr_sync_bin - rd_bin_q;
    end
  end

  assign rd_level = rd_level_q;
`else
  assign rd_level = '0;
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// tb_fifo_rd_ctrl: directed bench for fifo_rd_ctrl with a word-queue model checked every cycle.
// The rd_level checks switch on with FIFO_RD_LEVEL_EN, matching the DUT build.
module tb_fifo_rd_ctrl;

  localparam int DW = 8;
  localparam int AW = 4;

  logic          rd_clk = 1'b0;
  logic          rd_rst_n;
  logic [AW:0]   wr_ptr_gray;
  logic [AW:0]   rd_ptr_gray;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] mem_rd_data = '0;
  logic          empty;
  logic [AW:0]   rd_level;

  fifo_rd_ctrl_if #(.DATA_WIDTH(DW)) rd_if ();

  fifo_rd_ctrl #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW)
  ) dut (
    .rd_clk      (rd_clk),
    .rd_rst_n    (rd_rst_n),
    .wr_ptr_gray (wr_ptr_gray),
    .rd_ptr_gray (rd_ptr_gray),
    .rd_addr     (rd_addr),
    .mem_rd_data (mem_rd_data),
    .rd_if       (rd_if),
    .empty       (empty),
    .rd_level    (rd_level)
  );

  always #5 rd_clk = ~rd_clk;

  // Memory with a registered read port, as the controller expects.
  logic [DW-1:0] mem [16];
  always @(posedge rd_clk) mem_rd_data <= mem[rd_addr];

  int            n_cmp = 0;
  int            n_bad = 0;
  int            wr_cnt = 0;
  int            popped = 0;
  int            wr_d1, wr_d2;
  logic [DW-1:0] exp_q [$];

  // Write count as the read side can see it, two read-clock edges late.
  always @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      wr_d1 <= 0;
      wr_d2 <= 0;
    end else begin
      wr_d1 <= wr_cnt % 32;
      wr_d2 <= wr_d1;
    end
  end

  function automatic logic [4:0] to_gray(input int n);
    logic [4:0] b;
    b = 5'(n % 32);
    return b ^ (b >> 1);
  endfunction

  function automatic int from_gray(input logic [4:0] g);
    logic [4:0] b;
    b[4] = g[4];
    for (int i = 3; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return int'(b);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge rd_clk);
    #2;
  endtask

  task automatic write_word(input logic [DW-1:0] data);
    mem[wr_cnt % 16] = data;
    exp_q.push_back(data);
    wr_cnt = wr_cnt + 1;
    wr_ptr_gray = to_gray(wr_cnt);
  endtask

  task automatic apply_reset();
    rd_rst_n = 1'b0;
    exp_q.delete();
    wr_cnt = 0;
    wr_ptr_gray = '0;
    rd_if.dout_ready = 1'b0;
    repeat (2) tick();
    rd_rst_n = 1'b1;
  endtask

  task automatic wait_valid(input string name, input int budget);
    int n = 0;
    while (!rd_if.dout_valid && n < budget) begin
      tick();
      n++;
    end
    check({name, "_valid_within_budget"}, rd_if.dout_valid, 1);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || !empty) && n < 200) begin
      tick();
      n++;
    end
    check({name, "_drained"}, (exp_q.size() == 0) && empty, 1);
  endtask

  // Per-cycle compare against the word-queue model, sampled on the falling edge.
  initial begin : compare
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_dout  = '0;
    int            n, lead;
    forever begin
      @(negedge rd_clk);
      if (!rd_rst_n) begin
        popped     = 0;
        prev_stall = 1'b0;
      end else begin
        n    = from_gray(rd_ptr_gray);
        lead = (n - popped + 32) % 32;
        check("rd_addr_matches_ptr", 32'(rd_addr), n % 16);
        check("rd_ptr_lead_le_2", 32'(lead <= 2), 1);
        check("empty_flag", 32'(empty), 32'(wr_d2 == popped));
        if (prev_stall) begin
          check("stall_valid_held", 32'(rd_if.dout_valid), 1);
          check("stall_dout_held", 32'(rd_if.dout), 32'(prev_dout));
        end
        if (rd_if.dout_valid) begin
          check("word_expected", 32'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) check("dout_order", 32'(rd_if.dout), 32'(exp_q[0]));
        end
        prev_stall = rd_if.dout_valid && !rd_if.dout_ready;
        prev_dout  = rd_if.dout;
        if (rd_if.dout_valid && rd_if.dout_ready && exp_q.size() != 0) begin
          void'(exp_q.pop_front());
          popped = (popped + 1) % 32;
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1);
  end

  initial begin : stimulus
    for (int i = 0; i < 16; i++) mem[i] = '0;
    rd_rst_n         = 1'b0;
    wr_ptr_gray      = '0;
    rd_if.dout_ready = 1'b0;
    #1;
    check("rst_empty", 32'(empty), 1);
    check("rst_valid", 32'(rd_if.dout_valid), 0);
    check("rst_rd_addr", 32'(rd_addr), 0);
    check("rst_rd_ptr_gray", 32'(rd_ptr_gray), 0);
    check("rst_dout", 32'(rd_if.dout), 0);
    check("rst_rd_level", 32'(rd_level), 0);
    repeat (2) tick();
    rd_rst_n = 1'b1;

    // Idle after release with nothing written.
    for (int i = 0; i < 5; i++) begin
      tick();
      check("idle_empty", 32'(empty), 1);
      check("idle_valid", 32'(rd_if.dout_valid), 0);
      check("idle_rd_addr", 32'(rd_addr), 0);
    end

    // Single word: issue on the 3rd edge after the pointer change, data one edge later.
    rd_if.dout_ready = 1'b1;
    write_word(8'hA5);
    tick();
    check("one_e1_valid", 32'(rd_if.dout_valid), 0);
    check("one_e1_rd_addr", 32'(rd_addr), 0);
    tick();
    check("one_e2_rd_addr", 32'(rd_addr), 0);
    tick();
    check("one_e3_rd_addr", 32'(rd_addr), 1);
    check("one_e3_rd_ptr_gray", 32'(rd_ptr_gray), 32'h01);
    check("one_e3_valid", 32'(rd_if.dout_valid), 0);
    tick();
    check("one_e4_valid", 32'(rd_if.dout_valid), 1);
    check("one_e4_dout", 32'(rd_if.dout), 32'hA5);
    tick();
    check("one_e5_valid", 32'(rd_if.dout_valid), 0);
    check("one_e5_empty", 32'(empty), 1);

    // Full memory, ready high: sixteen back-to-back words.
    apply_reset();
    rd_if.dout_ready = 1'b1;
    for (int i = 0; i < 16; i++) write_word(8'(i * 13 + 7));
    wait_valid("burst", 10);
    check("burst_first_dout", 32'(rd_if.dout), 32'h07);
    for (int i = 1; i < 16; i++) begin
      tick();
      check("burst_no_gap", 32'(rd_if.dout_valid), 1);
    end
    check("burst_last_dout", 32'(rd_if.dout), 32'hCA);
    tick();
    check("burst_end_valid", 32'(rd_if.dout_valid), 0);
    check("burst_rd_ptr_gray", 32'(rd_ptr_gray), 32'h18);
    check("burst_empty", 32'(empty), 1);

    // Back-pressure: only two words leave memory while the consumer stalls.
    apply_reset();
    for (int i = 0; i < 4; i++) write_word(8'(8'hC0 + i));
    repeat (10) tick();
    check("stall_rd_addr", 32'(rd_addr), 2);
    check("stall_rd_ptr_gray", 32'(rd_ptr_gray), 32'h03);
    check("stall_valid", 32'(rd_if.dout_valid), 1);
    check("stall_dout", 32'(rd_if.dout), 32'hC0);
    rd_if.dout_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      tick();
      check("release_valid", 32'(rd_if.dout_valid), 1);
      check("release_dout", 32'(rd_if.dout), 32'(8'hC0 + i));
    end
    tick();
    check("release_end_valid", 32'(rd_if.dout_valid), 0);

    // Pointer wrap: 31 words, then one across the wrap, then one more.
    apply_reset();
    rd_if.dout_ready = 1'b1;
    for (int i = 0; i < 16; i++) write_word(8'(8'h40 + i));
    wait_drain("wrap_a");
    for (int i = 16; i < 31; i++) write_word(8'(8'h40 + i));
    wait_drain("wrap_b");
    check("wrap31_rd_ptr_gray", 32'(rd_ptr_gray), 32'h10);
    check("wrap31_rd_addr", 32'(rd_addr), 15);
    write_word(8'h9E);
    wait_drain("wrap_c");
    check("wrap32_rd_ptr_gray", 32'(rd_ptr_gray), 32'h00);
    check("wrap32_rd_addr", 32'(rd_addr), 0);
    write_word(8'h9F);
    wait_drain("wrap_d");
    check("wrap33_rd_ptr_gray", 32'(rd_ptr_gray), 32'h01);
    check("wrap33_rd_addr", 32'(rd_addr), 1);

    // Reset with two words buffered: output clears at once, nothing survives.
    apply_reset();
    write_word(8'h11);
    write_word(8'h22);
    repeat (8) tick();
    check("prerst_valid", 32'(rd_if.dout_valid), 1);
    check("prerst_dout", 32'(rd_if.dout), 32'h11);
    rd_rst_n = 1'b0;
    exp_q.delete();
    wr_cnt = 0;
    wr_ptr_gray = '0;
    #1;
    check("midrst_valid", 32'(rd_if.dout_valid), 0);
    check("midrst_empty", 32'(empty), 1);
    check("midrst_rd_level", 32'(rd_level), 0);
    repeat (2) tick();
    rd_rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("postrst_valid", 32'(rd_if.dout_valid), 0);
    end
    for (int i = 0; i < 3; i++) write_word(8'(8'h31 + i));
    repeat (10) tick();
`ifdef FIFO_RD_LEVEL_EN
    check("level_written_minus_read", 32'(rd_level), 1);
`else
    check("level_tied_off", 32'(rd_level), 0);
`endif
    rd_if.dout_ready = 1'b1;
    wait_drain("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fifo_rd_ctrl.md
FIFO_RD_CTRL -- requirements
Module: fifo_rd_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4, memory address width; depth = 2**ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits.
REQ-003 SHALL use one clock and an asynchronous active-low reset: rd_clk  input  1  read-domain clock, rising edge.
REQ-004 rd_rst_n  input  1  asynchronous active-low reset.
REQ-005 wr_ptr_gray  input  ADDR_WIDTH+1  write pointer, Gray-coded, asynchronous to rd_clk.
REQ-006 rd_ptr_gray  output  ADDR_WIDTH+1  read pointer, Gray-coded, registered, to write domain.
REQ-007 rd_addr  output  ADDR_WIDTH  address driven to the memory read port.
REQ-008 mem_rd_data  input  DATA_WIDTH  memory read data, registered by memory on rd_clk.
REQ-009 dout  output  DATA_WIDTH  head word of output buffer.
REQ-010 dout_valid  output  1  dout holds a valid word.
REQ-011 dout_ready  input  1  consumer accepts dout this cycle.
REQ-012 empty  output  1  no word in memory and none in flight or buffered.
REQ-013 rd_level  output  ADDR_WIDTH+1  words in memory not yet issued (see Configuration).

Function
REQ-014 SHALL synchronise wr_ptr_gray through two rd_clk flops before any use.
REQ-015 mem_empty SHALL be true when rd_ptr_gray equals synchronised write pointer.
REQ-016 rd_addr SHALL equal the low ADDR_WIDTH bits of the binary read pointer at all times.
REQ-017 Issue SHALL occur on an edge where mem_empty is false and (buffer occupancy + in-flight) < 2; binary pointer increments by 1, Gray pointer = bin ^ (bin >> 1) registered same edge.
REQ-018 Pointer SHALL wrap from 2**(ADDR_WIDTH+1)-1 to 0; MSB toggles on each address wrap.
REQ-019 Issued word SHALL be written into a 2-entry output buffer on the edge following issue (mem_rd_data sampled then); in-flight flag set for exactly that cycle.
REQ-020 dout_valid SHALL rise on the capture edge, i.e. one cycle after issue edge; dout = oldest buffered word.
REQ-021 Transfer SHALL occur when dout_valid && dout_ready; simultaneous capture and transfer keeps occupancy unchanged and preserves order.
REQ-022 dout and dout_valid SHALL hold stable while dout_valid && !dout_ready.
REQ-023 With dout_ready held high and memory non-empty, sustained throughput SHALL be one word per cycle.
REQ-024 empty SHALL = mem_empty && !in_flight && occupancy==0.
REQ-025 Words SHALL never be lost or duplicated, including when wr_ptr_gray changes in the cycle an issue occurs.

Reset
REQ-026 On rd_rst_n low, asynchronously: pointers 0, rd_ptr_gray 0, rd_addr 0, sync flops 0, buffer occupancy 0, in-flight 0, dout 0, dout_valid 0, empty 1, rd_level 0.
REQ-027 Reset asserted mid-transfer SHALL discard buffered and in-flight words; first issue after release no earlier than third rd_clk edge (sync pipeline refill).

Configuration
REQ-028 Macro FIFO_RD_LEVEL_EN defined: rd_level SHALL be registered (synchronised write pointer converted Gray-to-binary) minus binary read pointer, modulo 2**(ADDR_WIDTH+1), updated every edge.
REQ-029 Macro undefined: rd_level SHALL be tied to 0 and no conversion logic built; port list unchanged.

Structure
REQ-030 Shared package fifo_pkg SHALL hold Gray/binary conversion functions and pointer-width constant PTR_WIDTH = ADDR_WIDTH+1 derivation.
REQ-031 Two-flop synchroniser SHALL be a separate sub-module cdc_sync_2ff, parameterised by width, reset to 0 on rd_rst_n.

Verification
REQ-032 Reset release, wr_ptr_gray=0 -> empty=1, dout_valid=0, rd_addr=0 for all cycles.
REQ-033 wr_ptr_gray steps to 1 (bin 1), mem[0]=8'hA5, dout_ready=1 -> issue at 3rd edge after change, dout_valid=1 with dout=8'hA5 one edge later, then empty=1.
REQ-034 16 words preloaded (wr_ptr_gray = gray(16)=5'b11000), dout_ready=1 -> 16 consecutive valid cycles, data in order, rd_ptr_gray ends 5'b11000.
REQ-035 dout_ready=0 with 4 words available -> exactly 2 issues, dout stalls on first word, rd_addr=2; release ready -> remaining words in order, no gaps.
REQ-036 Pointer wrap: read 31 words, then 2 more -> binary pointer 31->0->1, rd_ptr_gray 5'b10000->5'b00000->5'b00001, data correct.
REQ-037 rd_rst_n pulsed low with 2 words buffered -> dout_valid=0 immediately; with FIFO_RD_LEVEL_EN, rd_level=0 in reset and equals written-minus-read count after.
